// File: rtl/axis_throttled_packer.sv
// Packs a stream of narrow words into wide output beats (lane 0 = first word).
// A single output register is fed either directly by the completing word or
// from a parked full accumulator. An LFSR throttle decides in which cycles a
// pending beat is presented on m_valid. Once presented, a beat holds until it
// is accepted.
//
// Accumulator FSM
//   state    | meaning
//   ACC_FILL | collecting words into lanes, in_ready high
//   ACC_DONE | beat complete but output register busy, input stalled
//
// Output register FSM
//   state     | meaning
//   OUT_EMPTY | no beat held
//   OUT_FULL  | beat held; m_valid shows whether it has been presented yet

module axis_throttled_packer #(
   parameter int          WORD_W     = 8,
   parameter int          BUS_W      = 32,
   parameter int          VALID_PROB = 256,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         WPB        = BUS_W / WORD_W
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WORD_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WPB-1:0][WORD_W-1:0]    m_data,
   output logic [WPB-1:0]                m_keep,
   output logic                          m_last,
   output logic [31:0]                   beat_cnt
);

   localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

   if (WORD_W < 1 || BUS_W < WORD_W || (BUS_W % WORD_W) != 0) begin : g_bad_width
      $error("axis_throttled_packer: BUS_W must be a nonzero multiple of WORD_W");
   end
   if (VALID_PROB < 0 || VALID_PROB > 256) begin : g_bad_prob
      $error("axis_throttled_packer: VALID_PROB must lie in 0..256");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("axis_throttled_packer: LFSR_SEED must be nonzero");
   end

   typedef enum logic {ACC_FILL, ACC_DONE}  acc_state_t;
   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

   acc_state_t                 acc_state;
   out_state_t                 out_state;
   logic [IDX_W-1:0]           lane_idx;
   logic [WPB-1:0][WORD_W-1:0] acc_data;
   logic [WPB-1:0]             acc_keep;
   logic                       acc_last;
   logic [15:0]                lfsr;

   logic                       in_fire;
   logic                       out_fire;
   logic                       out_free;
   logic                       beat_done;
   logic                       load_from_acc;
   logic                       load_from_in;
   logic                       throttle_ok;
   logic                       lfsr_fb;
   logic [WPB-1:0][WORD_W-1:0] merge_data;
   logic [WPB-1:0]             merge_keep;

   // handshake qualifiers and load decisions, derived from state and inputs
   always_comb begin
      // gated by rstn so in_ready reads 0 for the whole reset assertion
      in_ready      = rstn & (acc_state == ACC_FILL);
      in_fire       = in_valid & in_ready;
      out_fire      = m_valid & m_ready;
      out_free      = (out_state == OUT_EMPTY) | out_fire;
      beat_done     = in_fire & (in_last | (lane_idx == IDX_W'(WPB - 1)));
      load_from_acc = (acc_state == ACC_DONE) & out_free;
      load_from_in  = beat_done & out_free;
      // 9-bit compare so VALID_PROB=256 always passes and 0 never does
      throttle_ok   = {1'b0, lfsr[7:0]} < 9'(VALID_PROB);
      lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   end

   // accumulator contents with the incoming word dropped into its lane
   always_comb begin
      merge_data = acc_data;
      merge_keep = acc_keep;
      for (int i = 0; i < WPB; i++) begin
         if (lane_idx == IDX_W'(i)) begin
            merge_data[i] = in_data;
            merge_keep[i] = 1'b1;
         end
      end
   end

   // accumulator FSM: fill lanes, park a completed beat while the output is busy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_state <= ACC_FILL;
         lane_idx  <= '0;
         acc_data  <= '0;
         acc_keep  <= '0;
         acc_last  <= 1'b0;
      end else begin
         case (acc_state)
            ACC_FILL: begin
               if (beat_done) begin
                  if (out_free) begin
                     // beat went straight to the output register
                     lane_idx <= '0;
                     acc_data <= '0;
                     acc_keep <= '0;
                     acc_last <= 1'b0;
                  end else begin
                     acc_state <= ACC_DONE;
                     acc_data  <= merge_data;
                     acc_keep  <= merge_keep;
                     acc_last  <= in_last;
                  end
               end else if (in_fire) begin
                  acc_data <= merge_data;
                  acc_keep <= merge_keep;
                  lane_idx <= lane_idx + 1'b1;
               end
            end
            ACC_DONE: begin
               if (out_free) begin
                  acc_state <= ACC_FILL;
                  lane_idx  <= '0;
                  acc_data  <= '0;
                  acc_keep  <= '0;
                  acc_last  <= 1'b0;
               end
            end
            default: acc_state <= ACC_FILL;
         endcase
      end
   end

   // output register FSM: load a beat, present it when the throttle allows, hold until taken
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_state <= OUT_EMPTY;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_keep    <= '0;
         m_last    <= 1'b0;
      end else begin
         if (load_from_acc || load_from_in) begin
            out_state <= OUT_FULL;
            m_valid   <= throttle_ok;
            if (load_from_acc) begin
               m_data <= acc_data;
               m_keep <= acc_keep;
               m_last <= acc_last;
            end else begin
               m_data <= merge_data;
               m_keep <= merge_keep;
               m_last <= in_last;
            end
         end else if (out_fire) begin
            out_state <= OUT_EMPTY;
            m_valid   <= 1'b0;
         end else if (out_state == OUT_FULL && !m_valid && throttle_ok) begin
            m_valid <= 1'b1;
         end
      end
   end

   // throttle LFSR, free running
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   // completed output handshakes, wrapping
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt <= '0;
      end else if (out_fire) begin
         beat_cnt <= beat_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_axis_throttled_packer.sv
// Bench for axis_throttled_packer. Instance 0 runs with the throttle wide open
// for directed cases; instance 1 runs with VALID_PROB=64 under random traffic.
// Expected beats come from chunking each packet into groups of four words.

module tb_axis_throttled_packer;

   logic        clk;
   logic        rstn     [2];
   logic        in_valid [2];
   logic        in_ready [2];
   logic [7:0]  in_data  [2];
   logic        in_last  [2];
   logic        m_valid  [2];
   logic        m_ready  [2];
   logic [31:0] m_data   [2];
   logic [3:0]  m_keep   [2];
   logic        m_last   [2];
   logic [31:0] beat_cnt [2];

   axis_throttled_packer u_dut (
      .clk(clk), .rstn(rstn[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_keep(m_keep[0]),
      .m_last(m_last[0]), .beat_cnt(beat_cnt[0])
   );

   axis_throttled_packer #(.VALID_PROB(64)) u_dut_thr (
      .clk(clk), .rstn(rstn[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_keep(m_keep[1]),
      .m_last(m_last[1]), .beat_cnt(beat_cnt[1])
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_timeout = 0;
   int          cyc = 0;
   int          n_hs [2];
   int          opps = 0;
   int          rises = 0;
   bit          prev_opp = 0;
   bit          hold [2];
   logic [36:0] held [2];
   logic [36:0] q0 [$];
   logic [36:0] q1 [$];
   logic [7:0]  pkt [2][16];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push_beat(input int u, input logic [36:0] v);
      if (u == 0) q0.push_back(v);
      else q1.push_back(v);
   endtask

   function automatic logic [36:0] pop_beat(input int u);
      if (u == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   // reference: split pkt[u][0..len-1] into beats of up to four words
   task automatic model_packet(input int u, input int len);
      for (int i = 0; i < len; i += 4) begin
         logic [31:0] d;
         logic [3:0]  k;
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++) begin
            if (i + j < len) begin
               d[8*j +: 8] = pkt[u][i+j];
               k[j] = 1'b1;
            end
         end
         push_beat(u, {(i + 4 >= len), k, d});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one word and wait for it to be accepted; entered and left at posedge+1
   task automatic send_word(input int u, input logic [7:0] d, input logic l);
      bit ok;
      ok = 0;
      in_valid[u] = 1'b1;
      in_data[u]  = d;
      in_last[u]  = l;
      for (int k = 0; k < 4000 && !ok; k++) begin
         @(negedge clk);
         if (in_ready[u]) ok = 1;
         step();
      end
      in_valid[u] = 1'b0;
      in_last[u]  = 1'b0;
      if (!ok) n_timeout++;
   endtask

   task automatic send_packet(input int u, input int len, input int base, input bit gaps);
      for (int i = 0; i < len; i++)
         pkt[u][i] = (base < 0) ? 8'($urandom) : 8'(base + i);
      model_packet(u, len);
      for (int i = 0; i < len; i++) begin
         send_word(u, pkt[u][i], i == len - 1);
         if (gaps && $urandom_range(0, 3) == 0) step();
      end
   endtask

   task automatic drain(input int u, input string tag);
      for (int k = 0; k < 3000 && qsize(u) != 0; k++) step();
      chk(tag, qsize(u), 0);
   endtask

   // output monitor: scoreboard, hold-until-accepted, throttle rate on instance 1
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         logic [36:0] cur;
         cur = {m_last[u], m_keep[u], m_data[u]};
         if (!rstn[u]) begin
            hold[u] = 0;
            n_hs[u] = 0;
            if (u == 1) prev_opp = 0;
         end else begin
            if (hold[u]) begin
               chk("hold_m_valid", m_valid[u], 1'b1);
               chk("hold_beat", cur, held[u]);
            end
            if (m_valid[u] && m_ready[u]) begin
               n_hs[u]++;
               if (qsize(u) == 0) chk("unexpected_beat", cur, 37'h0);
               else chk((u == 0) ? "beat_dut0" : "beat_dut1", cur, pop_beat(u));
            end
            hold[u] = m_valid[u] && !m_ready[u];
            held[u] = cur;
            if (u == 1) begin
               if (prev_opp && m_valid[1]) rises++;
               prev_opp = !m_valid[1] && !in_ready[1];
               if (prev_opp) opps++;
            end
         end
      end
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rstn[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = '0;
         in_last[u] = 1'b0; m_ready[u] = 1'b0; n_hs[u] = 0;
      end
      #12;
      chk("rst_m_valid", m_valid[0], 1'b0);
      chk("rst_m_last", m_last[0], 1'b0);
      chk("rst_m_keep", m_keep[0], 4'h0);
      chk("rst_m_data", m_data[0], 32'h0);
      chk("rst_in_ready", in_ready[0], 1'b0);
      chk("rst_beat_cnt", beat_cnt[0], 32'h0);
      chk("rst_thr_m_valid", m_valid[1], 1'b0);
      step();
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      @(negedge clk);
      chk("rel_in_ready0", in_ready[0], 1'b1);
      chk("rel_in_ready1", in_ready[1], 1'b1);
      step();

      fork
         begin : directed
            int c0;
            int w;
            // eight words, two full beats
            m_ready[0] = 1'b1;
            for (int i = 0; i < 8; i++) pkt[0][i] = 8'(i + 1);
            model_packet(0, 8);
            for (int i = 0; i < 8; i++) begin
               send_word(0, pkt[0][i], i == 7);
               if (i == 3) chk("latency_m_valid", m_valid[0], 1'b1);
            end
            drain(0, "drain_8w");
            @(negedge clk);
            chk("beat_cnt_2", beat_cnt[0], 32'd2);
            step();

            // five words, short second beat
            send_packet(0, 5, 'h11, 0);
            drain(0, "drain_5w");

            // backpressure: 12 words offered for 20 cycles with m_ready low
            m_ready[0] = 1'b0;
            for (int i = 0; i < 12; i++) pkt[0][i] = 8'('h21 + i);
            model_packet(0, 12);
            w = 0;
            for (int k = 0; k < 20; k++) begin
               bit acc;
               acc = 0;
               in_valid[0] = 1'b1;
               in_data[0]  = pkt[0][w];
               in_last[0]  = (w == 11);
               @(negedge clk);
               if (in_ready[0]) acc = 1;
               step();
               if (acc) w++;
            end
            in_valid[0] = 1'b0;
            in_last[0]  = 1'b0;
            chk("bp_accepted", w, 8);
            chk("bp_in_ready", in_ready[0], 1'b0);
            chk("bp_m_valid", m_valid[0], 1'b1);
            chk("bp_m_data", m_data[0], 32'h24232221);
            m_ready[0] = 1'b1;
            for (int i = w; i < 12; i++) send_word(0, pkt[0][i], i == 11);
            drain(0, "drain_bp");

            // back-to-back single-word packets
            c0 = cyc;
            for (int i = 0; i < 8; i++) begin
               pkt[0][0] = 8'('h50 + i);
               model_packet(0, 1);
               send_word(0, pkt[0][0], 1'b1);
               chk("b2b_m_valid", m_valid[0], 1'b1);
            end
            chk("b2b_cycles", cyc - c0, 8);
            drain(0, "drain_b2b");

            // reset mid-packet with a presented beat pending
            m_ready[0] = 1'b0;
            for (int i = 0; i < 6; i++) send_word(0, 8'('h31 + i), 1'b0);
            chk("pre_rst_m_valid", m_valid[0], 1'b1);
            #2;
            rstn[0] = 1'b0;
            #1;
            chk("rst_async_m_valid", m_valid[0], 1'b0);
            chk("rst_async_beat_cnt", beat_cnt[0], 32'h0);
            chk("rst_async_m_keep", m_keep[0], 4'h0);
            q0.delete();
            step();
            step();
            rstn[0] = 1'b1;
            @(negedge clk);
            chk("post_rst_in_ready", in_ready[0], 1'b1);
            step();
            m_ready[0] = 1'b1;
            send_packet(0, 7, 'h41, 0);
            drain(0, "drain_post_rst");
         end
         begin : randomized
            bit rnd_done;
            rnd_done = 0;
            fork
               begin
                  for (int p = 0; p < 1000; p++)
                     send_packet(1, $urandom_range(1, 9), -1, 1);
                  rnd_done = 1;
               end
               begin
                  while (!rnd_done) begin
                     step();
                     m_ready[1] = ($urandom_range(0, 3) != 0);
                  end
               end
            join
            m_ready[1] = 1'b1;
            drain(1, "drain_rand");
            chk("rate_samples", opps >= 100, 1'b1);
            chk("rate_window", (rises * 100 >= opps * 15) && (rises * 100 <= opps * 35), 1'b1);
         end
      join

      repeat (4) step();
      @(negedge clk);
      chk("beat_cnt_dut0", beat_cnt[0], 32'(n_hs[0]));
      chk("beat_cnt_dut1", beat_cnt[1], 32'(n_hs[1]));
      chk("no_timeouts", n_timeout, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_throttled_packer.md
AXIS_THROTTLED_PACKER -- requirements
Module: axis_throttled_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bits per word.
REQ-002 SHALL have parameter BUS_W, default 32, output bus bits; elaboration SHALL fail unless BUS_W is a nonzero multiple of WORD_W.
REQ-003 SHALL have parameter VALID_PROB, default 256, range 0..256; probability, in 256ths, that a pending output beat is presented in a given cycle.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero; throttle LFSR reset value.
REQ-005 SHALL define localparam WPB = BUS_W/WORD_W, words per beat.
REQ-006 SHALL have one clock; reset is asynchronous and active-low. Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  WORD_W  input word
in_last  in  1  final word of packet
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  WPB x WORD_W  packed beat, lane 0 = first word
m_keep  out  WPB  lane-valid mask
m_last  out  1  final beat of packet
beat_cnt  out  32  count of completed output handshakes, wraps

Function
REQ-007 SHALL fill an accumulator lane by lane from lane 0, one word per input handshake.
REQ-008 SHALL complete a beat when lane WPB-1 is written or when in_last is accepted; m_keep = ones for written lanes only, m_last = accepted in_last.
REQ-009 SHALL drive unwritten lanes of m_data to zero, never X.
REQ-010 SHALL hold one output register (states EMPTY/FULL) and one accumulator (states FILL/DONE).
REQ-011 On beat completion, SHALL load the beat directly into the output register at that edge if the register is EMPTY or handshakes in the same cycle; otherwise the accumulator SHALL enter DONE.
REQ-012 In DONE, the accumulator SHALL transfer to the output register on the first edge where the register is EMPTY or handshakes, then return to FILL with lane index 0.
REQ-013 in_ready SHALL equal accumulator state FILL, combinational only from state.
REQ-014 Throttle: 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle; a FULL, not-yet-presented beat SHALL raise m_valid at the edge where lfsr[7:0] < VALID_PROB; VALID_PROB=256 always presents and VALID_PROB=0 never presents.
REQ-015 Once m_valid is high, m_valid, m_data, m_keep and m_last SHALL remain stable until m_valid & m_ready.
REQ-016 With VALID_PROB=256 and m_ready=1, m_valid SHALL rise one cycle after the completing input handshake, and sustained throughput SHALL be one beat per cycle whenever input supplies WPB words per beat period.
REQ-017 With WPB=1, every accepted word SHALL form one beat with m_keep=1.
REQ-018 beat_cnt SHALL increment by 1 per output handshake, wrapping 2^32-1 -> 0.
REQ-019 Packet word order SHALL be preserved end to end; no word is dropped or duplicated under any backpressure pattern.

Reset
REQ-020 While rstn=0: m_valid=0, m_last=0, m_keep=0, m_data=0, in_ready=0, beat_cnt=0, LFSR=LFSR_SEED, accumulator FILL at lane 0, output register EMPTY.
REQ-021 Reset asserted mid-packet SHALL discard partial and pending beats; the first cycle after release SHALL show in_ready=1.

Verification (WORD_W=8, BUS_W=32 unless stated)
REQ-022 Input words 1..8 with in_last on 8, m_ready=1, VALID_PROB=256 -> beats {4,3,2,1} and {8,7,6,5}, m_keep=4'hF, m_last only on the second beat, beat_cnt=2.
REQ-023 5-word packet -> second beat m_keep=4'b0001, lanes 1-3 zero, m_last=1.
REQ-024 m_ready=0 for 20 cycles while 12 words are offered -> 8 words accepted, then in_ready=0; m_data stable; m_ready=1 -> 3 beats in order.
REQ-025 VALID_PROB=64, 1000 random packets, random m_ready -> scoreboard match, m_valid never drops without a handshake, presentation rate ~25%.
REQ-026 rstn pulsed low with m_valid=1 mid-packet -> m_valid=0 asynchronously, beat_cnt=0; the next packet is received intact.
REQ-027 Back-to-back single-word packets, m_ready=1 -> one beat per cycle, m_keep=4'b0001, m_last=1 on each beat.
